// File: rtl/sdiv32x16.sv
`default_nettype none
// ============================================================================
// Module   : sdiv32x16
// Purpose  : Sequential signed divider, DIVIDEND_W / DIVISOR_W bits, using a
//            sign-magnitude radix-2 restoring core. It has valid/ready
//            handshakes on input and output. It produces one quotient bit per
//            cycle, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module sdiv32x16 #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]      C_CNT_INIT = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] C_Q_MAX    = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] C_Q_MIN    = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic                  r_dz;
    logic                  r_ov;
    logic [DIVISOR_W-1:0]  r_dvd_lo;
    // The dividend magnitude shifts out of the top of this register while the
    // quotient bits shift in at the bottom, so it holds |q| after the last step.
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W:0]    r_prem;
    logic                  r_out_valid;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;
    logic                  r_overflow;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic                  w_dz;
    logic                  w_ov;
    logic [DIVISOR_W+1:0]  w_shift;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_qbit;
    logic [DIVISOR_W:0]    w_prem_nxt;
    logic [DIVIDEND_W-1:0] w_quo_signed;
    logic [DIVISOR_W-1:0]  w_rem_signed;

    // Operand magnitudes and special-case detection at the accept cycle.
    assign w_dvd_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
    assign w_dsr_mag = divisor[DIVISOR_W-1]   ? (~divisor + 1'b1)  : divisor;
    assign w_dz      = (divisor == '0);
    assign w_ov      = (dividend == C_Q_MIN) && (divisor == '1);

    // The partial remainder is always below the divisor magnitude. Because of
    // that, the shifted value fits in DIVISOR_W+1 bits and the 17-bit difference
    // is exact whenever the trial succeeds.
    assign w_shift    = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_qbit     = (w_shift >= {2'b00, r_dsr});
    assign w_diff     = w_shift[DIVISOR_W:0] - {1'b0, r_dsr};
    assign w_prem_nxt = w_qbit ? w_diff : w_shift[DIVISOR_W:0];

    // Sign application on the unsigned core results.
    assign w_quo_signed = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
    assign w_rem_signed = r_sign_r ? (~r_prem[DIVISOR_W-1:0] + 1'b1)
                                   : r_prem[DIVISOR_W-1:0];

    // The input side is ready only in IDLE and never while reset is asserted.
    assign in_ready    = (r_state == S_IDLE) && !nvdla_core_rst;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

    // Control FSM with the datapath registers and the registered outputs.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dz          <= 1'b0;
            r_ov          <= 1'b0;
            r_dvd_lo      <= '0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_prem        <= '0;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_sign_r <= dividend[DIVIDEND_W-1];
                        r_dz     <= w_dz;
                        r_ov     <= w_ov;
                        r_dvd_lo <= dividend[DIVISOR_W-1:0];
                        r_dvd    <= w_dvd_mag;
                        r_dsr    <= w_dsr_mag;
                        r_prem   <= '0;
                        r_cnt    <= C_CNT_INIT;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Special cases still run every step so that latency stays uniform.
                    r_prem <= w_prem_nxt;
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero takes precedence over the single overflow pair.
                    if (r_dz) begin
                        r_quotient    <= r_sign_r ? C_Q_MIN : C_Q_MAX;
                        r_remainder   <= r_dvd_lo;
                        r_div_by_zero <= 1'b1;
                        r_overflow    <= 1'b0;
                    end else if (r_ov) begin
                        r_quotient    <= C_Q_MAX;
                        r_remainder   <= '0;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b1;
                    end else begin
                        r_quotient    <= w_quo_signed;
                        r_remainder   <= w_rem_signed;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdiv32x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdiv32x16
// Purpose  : Self-checking bench for sdiv32x16. An arithmetic reference model
//            feeds a scoreboard queue that is checked every out_valid cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdiv32x16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    sdiv32x16 #(.DIVIDEND_W(32), .DIVISOR_W(16)) u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dividend       (dividend),
        .divisor        (divisor),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .quotient       (quotient),
        .remainder      (remainder),
        .div_by_zero    (div_by_zero),
        .overflow       (overflow)
    );

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        bit          dz;
        bit          ov;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    bit     first_seen = 0;
    int     bp_mode = 0;   // 0: always ready, 1: hold off, 2: random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed arithmetic with truncating division plus the special cases.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output bit dz, output bit ov);
        longint sa, sb_, qq, rr;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        dz  = 0;
        ov  = 0;
        if (sb_ == 0) begin
            dz = 1;
            q  = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            r  = a[15:0];
        end else if (sa == -64'sd2147483648 && sb_ == -1) begin
            ov = 1;
            q  = 32'h7FFF_FFFF;
            r  = 16'h0000;
        end else begin
            qq = sa / sb_;
            rr = sa % sb_;
            q  = qq[31:0];
            r  = rr[15:0];
        end
    endfunction

    // Ready driver for the result side: it updates just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: every valid cycle is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                chk("quotient", quotient, sb[0].q);
                chk("remainder", remainder, sb[0].r);
                chk("div_by_zero", div_by_zero, sb[0].dz);
                chk("overflow", overflow, sb[0].ov);
                chk("in_ready_in_done", in_ready, 1'b0);
                if (!first_seen) begin
                    chk("latency", (cyc + 1) - sb[0].acc, 34);
                    first_seen = 1;
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    first_seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        model(a, b, e.q, e.r, e.dz, e.ov);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pin(input string name, input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] eq, input logic [15:0] er, input bit edz, input bit eov);
        logic [31:0] q;
        logic [15:0] r;
        bit dz, ov;
        model(a, b, q, r, dz, ov);
        chk({name, "_q"}, q, eq);
        chk({name, "_r"}, r, er);
        chk({name, "_flags"}, {dz, ov}, {edz, eov});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] fa;
        logic [31:0] mq;
        logic [15:0] mr;
        bit          mdz, mov;
        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {quotient, remainder, div_by_zero, overflow}, 50'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Hand-computed literal expectations for the model itself.
        pin("m_100_7",   32'd100,        16'd7,      32'd14,        16'd2,      0, 0);
        pin("m_n100_7",  32'hFFFF_FF9C,  16'd7,      32'hFFFF_FFF2, 16'hFFFE,   0, 0);
        pin("m_100_n7",  32'd100,        16'hFFF9,   32'hFFFF_FFF2, 16'd2,      0, 0);
        pin("m_n100_n7", 32'hFFFF_FF9C,  16'hFFF9,   32'd14,        16'hFFFE,   0, 0);
        pin("m_ovf",     32'h8000_0000,  16'hFFFF,   32'h7FFF_FFFF, 16'h0,      0, 1);
        pin("m_min_1",   32'h8000_0000,  16'h0001,   32'h8000_0000, 16'h0,      0, 0);
        pin("m_dz_pos",  32'd1234,       16'h0000,   32'h7FFF_FFFF, 16'h04D2,   1, 0);
        pin("m_dz_neg",  32'hFFFF_FFFB,  16'h0000,   32'h8000_0000, 16'hFFFB,   1, 0);

        // Directed cases through the DUT.
        send(32'd100, 16'd7);              wait_done();
        send(32'hFFFF_FF9C, 16'd7);        wait_done();
        send(32'd100, 16'hFFF9);           wait_done();
        send(32'hFFFF_FF9C, 16'hFFF9);     wait_done();
        send(32'h8000_0000, 16'hFFFF);     wait_done();
        send(32'h8000_0000, 16'h0001);     wait_done();
        send(32'd1234, 16'h0000);          wait_done();
        send(32'hFFFF_FFFB, 16'h0000);     wait_done();
        send(32'h7FFF_FFFF, 16'h8000);     wait_done();

        // Backpressure: hold the result for ten cycles while in_valid pulses.
        bp_mode = 1;
        @(negedge clk);
        send(32'h1234_5678, 16'h0123);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            in_valid = i[0];
            dividend = $urandom;
            divisor  = 16'($urandom);
        end
        in_valid = 1'b0;
        chk("bp_pending", sb.size(), 1);
        bp_mode = 0;
        wait_done();
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 1'b0);
        chk("bp_release_in_ready", in_ready, 1'b1);
        repeat (40) @(negedge clk);

        // Reset in the middle of the BUSY sequence.
        send(32'd100, 16'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        sb.delete();
        first_seen = 0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", {quotient, remainder, div_by_zero, overflow}, 50'h0);
        rst = 1'b0;
        #1;
        chk("midrst_idle", in_ready, 1'b1);
        send(32'd100, 16'd7);
        wait_done();

        // Random sweep with random backpressure and biased corner operands.
        bp_mode = 2;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'h0001;
                3:       b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'h0000_0000;
                2:       a = 32'($signed(16'($urandom)));
                default: a = $urandom;
            endcase
            send(a, b);
        end
        bp_mode = 0;
        wait_done();

        // Multiply-divide round trip: (a*b)/b must give back a.
        for (int i = 0; i < 25; i++) begin
            fa = 16'($urandom);
            b  = 16'($urandom);
            if (b == 16'h0000) b = 16'h0003;
            a  = 32'($signed(fa) * $signed(b));
            model(a, b, mq, mr, mdz, mov);
            chk("roundtrip_model", {mq, mr}, {32'($signed(fa)), 16'h0});
            send(a, b);
        end
        wait_done();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
